// File: rtl/rca_nibble_sequencer_if.sv
// Handshake and data bundle for rca_nibble_sequencer.
// The master issues requests and the sequencer (slave) returns registered results.
interface rca_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, s, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, s, cout, overflow
  );
endinterface

// File: rtl/rca_nibble_sequencer.sv
// Wide add/subtract built by time-sharing one 4-bit ripple-carry adder,
// one nibble per clock, LSB first, with the carry held between nibbles.
module rca_dataflow (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [4:0] c;

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s_o[gi]   = a_i[gi] ^ b_i[gi] ^ c[gi];
    assign c[gi+1]   = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = c[4];
endmodule

module rca_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rca_nibble_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        carry_q;
  logic [NIBBLES-1:0][3:0]     a_q;
  logic [NIBBLES-1:0][3:0]     bp_q;
  logic [NIBBLES-1:0][3:0]     s_q;
  logic                        cout_q;
  logic                        ovf_q;
  logic                        busy_q;
  logic                        done_q;

  logic [3:0]                  rca_sum;
  logic                        rca_co;
  logic                        last_nib;

  rca_dataflow u_rca (
    .a_i    (a_q[idx_q]),
    .b_i    (bp_q[idx_q]),
    .cin_i  (carry_q),
    .s_o    (rca_sum),
    .cout_o (rca_co)
  );

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // The DONE cycle's exit edge doubles as the first IDLE edge, so a start
  // presented while done is high is taken: one op every NIBBLES+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bp_q    <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            bp_q    <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          carry_q <= rca_co;
          idx_q   <= idx_q + 1'b1;
          if (last_nib) begin
            idx_q   <= '0;
            cout_q  <= rca_co;
            ovf_q   <= (a_q[NIBBLES-1][3] == bp_q[NIBBLES-1][3]) &&
                       (rca_sum[3] != a_q[NIBBLES-1][3]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Each result nibble only changes on the edge its slice passes the adder.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_snib
    always_ff @(posedge clk) begin
      if (reset) begin
        s_q[gi] <= 4'h0;
      end else if (state_q == S_RUN && idx_q == IDX_W'(gi)) begin
        s_q[gi] <= rca_sum;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.s        = s_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Scoreboard bench for rca_nibble_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_rca_nibble_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #10 clk = ~clk;

  rca_nibble_sequencer_if #(.NIBBLES(N)) ifc ();

  rca_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   prev_done_cyc = 0;
  int   saved_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor
  always @(negedge clk) begin
    check("busy_done_excl", 32'(ifc.busy & ifc.done), 32'd0);
    if (ifc.done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      check("busy_len", 32'(busy_cnt), 32'(N));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done (t=%0t)", $time);
      end else begin
        exp_e = exp_q.pop_front();
        $display("done: s=%h cout=%b ovf=%b exp s=%h cout=%b ovf=%b",
                 ifc.s, ifc.cout, ifc.overflow, exp_e.s, exp_e.c, exp_e.v);
        check("sum", 32'(ifc.s), 32'(exp_e.s));
        check("cout", 32'(ifc.cout), 32'(exp_e.c));
        check("overflow", 32'(ifc.overflow), 32'(exp_e.v));
      end
    end
    if (ifc.busy) busy_cnt++;
    else busy_cnt = 0;
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input bit push, input logic [W-1:0] es,
                       input logic ec, input logic ev);
    exp_t e;
    ifc.a     = a;
    ifc.b     = b;
    ifc.sub   = sub;
    ifc.cin   = cin;
    ifc.start = 1'b1;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.v = ev;
      exp_q.push_back(e);
    end
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!ifc.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done (t=%0t)", $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input logic [W-1:0] es, input logic ec,
                        input logic ev);
    @(negedge clk);
    issue(a, b, sub, cin, 1'b1, es, ec, ev);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.start = 1'b0;
    ifc.sub   = 1'b0;
    ifc.cin   = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_s", 32'(ifc.s), 32'd0);
    check("rst_cout", 32'(ifc.cout), 32'd0);
    check("rst_ovf", 32'(ifc.overflow), 32'd0);
    reset = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Start while busy is ignored; start on the done cycle is accepted.
    @(negedge clk);
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    ifc.a     = 16'hAAAA;
    ifc.b     = 16'h5555;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done();
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, 16'h1010, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);
    check("done_spacing_busy", 32'(last_done_cyc - prev_done_cyc), 32'(N + 1));

    // Reset mid-operation abandons it.
    @(negedge clk);
    saved_done_cnt = done_cnt;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(ifc.busy), 32'd0);
    check("midrst_s", 32'(ifc.s), 32'd0);
    check("midrst_cout", 32'(ifc.cout), 32'd0);
    check("midrst_ovf", 32'(ifc.overflow), 32'd0);
    repeat (8) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'(saved_done_cnt));
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    saved_done_cnt = done_cnt;
    reset = 1'b1;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rststart_busy", 32'(ifc.busy), 32'd0);
    repeat (7) @(negedge clk);
    check("rststart_no_done", 32'(done_cnt), 32'(saved_done_cnt));

    // Back-to-back at the earliest legal edges.
    @(negedge clk);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    repeat (N) @(negedge clk);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    check("done_spacing_b2b", 32'(last_done_cyc - prev_done_cyc), 32'(N + 1));

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
